if_id_buf_yw: RTL and testbench

//   IF/ID pipeline stage with a small instruction skid FIFO. Accepts fetched instructions from the

---
 rtl/if_id_buf_yw.sv | 278 +++++++++++++++++++++++++++
 tb/tb_if_id_buf_yw.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buf_yw.sv
// ---------------------------------------------------------------------------
// if_id_buf_yw : IF/ID pipeline stage with a small instruction skid FIFO.
//
// Fetched instructions arrive over a valid/ready handshake and are handed to
// the decoder through a single output register (one instruction per cycle).
// A DEPTH-entry FIFO absorbs decoder hold stalls. An execute-stage jump
// discards everything buffered and drives a NOP bubble.
//
// Optional feature macro: IF_ID_PERF_CNT_EN
//   defined   -> 32-bit stall and flush performance counters are built.
//   undefined -> no counter flops; stall_cnt_o / flush_cnt_o read 32'h0.
// ---------------------------------------------------------------------------
module if_id_buf_yw #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic        hold_flag_i,
  input  logic        jump_flag_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  // Pointer width covers DEPTH entries; the count needs one more bit so that
  // a full FIFO (count == DEPTH) is representable.
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  // Occupancy FSM; tracks the count so the empty/full decisions come from a
  // flop-level one-hot-ish encoding instead of a wide compare.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_PARTIAL = 2'b01,
    ST_FULL    = 2'b10
  } occ_e;

  occ_e          state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   mem_inst_q [DEPTH];
  logic [31:0]   mem_addr_q [DEPTH];

  logic [31:0]   inst_q, inst_d;
  logic [31:0]   addr_q, addr_d;
  logic          valid_q, valid_d;

  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          ready_s;
  logic          enq_s;
  logic          deq_s;
  logic          bypass_s;
  logic          wr_en_s;

  // ---------------------------------------------------------------------
  // Handshake and FIFO control decode
  // ---------------------------------------------------------------------
  assign fifo_empty_s = (state_q == ST_EMPTY);
  assign fifo_full_s  = (state_q == ST_FULL);

  // A full FIFO refuses new data even when a dequeue happens the same cycle,
  // which keeps ready free of any path from hold_flag_i or the output side.
  assign ready_s      = rst & ~jump_flag_i & ~fifo_full_s;
  assign inst_ready_o = ready_s;

  assign enq_s    = inst_valid_i & ready_s;
  assign deq_s    = ~jump_flag_i & ~hold_flag_i & ~fifo_empty_s;
  // Empty FIFO and an idle output slot: the new word skips the storage.
  assign bypass_s = ~jump_flag_i & ~hold_flag_i & fifo_empty_s & enq_s;
  assign wr_en_s  = enq_s & ~bypass_s;

  // Next-state logic for the occupancy FSM.
  always_comb begin
    state_d = state_q;
    if (jump_flag_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (wr_en_s && !deq_s) begin
            state_d = (count_q == CNT_LAST) ? ST_FULL : ST_PARTIAL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_PARTIAL: begin
          if (wr_en_s && !deq_s) begin
            state_d = (count_q == CNT_LAST) ? ST_FULL : ST_PARTIAL;
          end else if (deq_s && !wr_en_s) begin
            state_d = (count_q == CNT_ONE) ? ST_EMPTY : ST_PARTIAL;
          end else begin
            state_d = ST_PARTIAL;
          end
        end
        ST_FULL: begin
          if (deq_s && !wr_en_s) begin
            state_d = (count_q == CNT_ONE) ? ST_EMPTY : ST_PARTIAL;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Next-state logic for occupancy count and ring pointers.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (jump_flag_i) begin
      count_d  = CNT_ZERO;
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
    end else begin
      case ({wr_en_s, deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Next value of the decoder-facing output register, in priority order:
  // jump, hold, FIFO head, bypass, bubble.
  always_comb begin
    inst_d  = inst_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (jump_flag_i) begin
      inst_d  = NOP_INST;
      addr_d  = RST_ADDR;
      valid_d = 1'b0;
    end else if (hold_flag_i) begin
      inst_d  = inst_q;
      addr_d  = addr_q;
      valid_d = valid_q;
    end else if (deq_s) begin
      inst_d  = mem_inst_q[rd_ptr_q];
      addr_d  = mem_addr_q[rd_ptr_q];
      valid_d = 1'b1;
    end else if (bypass_s) begin
      inst_d  = inst_i;
      addr_d  = inst_addr_i;
      valid_d = 1'b1;
    end else begin
      // Bubble keeps the last address so the decoder sees a stable PC.
      inst_d  = NOP_INST;
      addr_d  = addr_q;
      valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------

  // Occupancy FSM, count and pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      count_q  <= CNT_ZERO;
      rd_ptr_q <= PTR_ZERO;
      wr_ptr_q <= PTR_ZERO;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so no stale instruction survives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= 32'h0000_0000;
        mem_addr_q[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      mem_inst_q[wr_ptr_q] <= inst_i;
      mem_addr_q[wr_ptr_q] <= inst_addr_i;
    end else begin
      mem_inst_q[wr_ptr_q] <= mem_inst_q[wr_ptr_q];
      mem_addr_q[wr_ptr_q] <= mem_addr_q[wr_ptr_q];
    end
  end

  // Decoder-facing output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inst_q  <= NOP_INST;
      addr_q  <= RST_ADDR;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_addr_o  = addr_q;
  assign inst_valid_o = valid_q;

  // ---------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold_flag_i) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (jump_flag_i) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers; counting only happens out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'h0000_0000;
  assign flush_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_id_buf_yw.sv
// ---------------------------------------------------------------------------
// tb_if_id_buf_yw : directed self-checking bench for if_id_buf_yw (DEPTH=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_if_id_buf_yw;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic        hold_flag_i;
  logic        jump_flag_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  int n_cmp;
  int n_bad;

  if_id_buf_yw #(
    .DEPTH   (2),
    .NOP_INST(32'h0000_0013),
    .RST_ADDR(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o),
    .hold_flag_i (hold_flag_i),
    .jump_flag_i (jump_flag_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .inst_valid_o(inst_valid_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] ei,
                         input logic [31:0] ea, input logic ev);
    n_cmp++;
    if (inst_o !== ei || inst_addr_o !== ea || inst_valid_o !== ev) begin
      n_bad++;
      $display("FAIL %s: got inst=%h addr=%h valid=%b, want inst=%h addr=%h valid=%b",
               nm, inst_o, inst_addr_o, inst_valid_o, ei, ea, ev);
    end
  endtask

  task automatic chk_rdy(input string nm, input logic er);
    #1;
    n_cmp++;
    if (inst_ready_o !== er) begin
      n_bad++;
      $display("FAIL %s: got ready=%b, want %b", nm, inst_ready_o, er);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; inst_valid_i = 1'b1; inst_i = 32'hDEAD_BEEF; inst_addr_i = 32'h0000_0040;
    hold_flag_i = 1'b0; jump_flag_i = 1'b0;
    step();
    step();
    chk_out("reset_out", NOP, 32'h0, 1'b0);
    chk_rdy("reset_ready", 1'b0);
    n_cmp++;
    if (stall_cnt_o !== 32'h0 || flush_cnt_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_cnt: got stall=%0d flush=%0d, want 0 0", stall_cnt_o, flush_cnt_o);
    end
    inst_valid_i = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_bypass();
    inst_valid_i = 1'b1; inst_i = 32'h0050_0093; inst_addr_i = 32'h0000_0100;
    chk_rdy("bypass_ready", 1'b1);
    step();
    inst_valid_i = 1'b0;
    chk_out("bypass_out", 32'h0050_0093, 32'h0000_0100, 1'b1);
    step();
    chk_out("bypass_bubble", NOP, 32'h0000_0100, 1'b0);
  endtask

  task automatic test_hold_fill();
    hold_flag_i = 1'b1; inst_valid_i = 1'b1;
    inst_i = 32'h1000_0104; inst_addr_i = 32'h0000_0104;
    chk_rdy("fill_ready0", 1'b1);
    step();
    chk_out("fill_hold0", NOP, 32'h0000_0100, 1'b0);
    inst_i = 32'h1000_0108; inst_addr_i = 32'h0000_0108;
    chk_rdy("fill_ready1", 1'b1);
    step();
    inst_i = 32'h1000_010C; inst_addr_i = 32'h0000_010C;
    chk_rdy("fill_ready_full", 1'b0);
    step();
    chk_out("fill_hold2", NOP, 32'h0000_0100, 1'b0);
    hold_flag_i = 1'b0;
    chk_rdy("full_no_accept_on_deq", 1'b0);
    step();
    chk_out("drain_0x104", 32'h1000_0104, 32'h0000_0104, 1'b1);
    chk_rdy("ready_after_deq", 1'b1);
    step();
    inst_valid_i = 1'b0;
    chk_out("drain_0x108", 32'h1000_0108, 32'h0000_0108, 1'b1);
    step();
    chk_out("drain_0x10C", 32'h1000_010C, 32'h0000_010C, 1'b1);
    step();
    chk_out("drain_bubble", NOP, 32'h0000_010C, 1'b0);
  endtask

  task automatic test_flush();
    hold_flag_i = 1'b1; inst_valid_i = 1'b1;
    inst_i = 32'h2000_0300; inst_addr_i = 32'h0000_0300;
    step();
    inst_i = 32'h2000_0304; inst_addr_i = 32'h0000_0304;
    step();
    inst_i = 32'h2000_0308; inst_addr_i = 32'h0000_0308;
    jump_flag_i = 1'b1;
    chk_rdy("jump_ready", 1'b0);
    step();
    jump_flag_i = 1'b0; hold_flag_i = 1'b0; inst_valid_i = 1'b0;
    chk_out("flush_out", NOP, 32'h0, 1'b0);
    chk_rdy("flush_ready", 1'b1);
    step();
    chk_out("flush_empty1", NOP, 32'h0, 1'b0);
    step();
    chk_out("flush_empty2", NOP, 32'h0, 1'b0);
  endtask

  task automatic test_stream();
    int sent;
    int rcv;
    int cyc;
    logic acc;
    logic hold_used;
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 20 && cyc < 200) begin
      hold_flag_i  = ((cyc % 5) == 2) || ((cyc % 7) == 5);
      inst_valid_i = (sent < 20);
      inst_i       = 32'h0A00_0000 + 32'(sent);
      inst_addr_i  = 32'h0000_0200 + 32'(4 * sent);
      #1;
      acc       = inst_valid_i & inst_ready_o;
      hold_used = hold_flag_i;
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (!hold_used && inst_valid_o) begin
        n_cmp++;
        if (rcv >= 20) begin
          n_bad++;
          $display("FAIL stream_extra: got inst=%h beyond 20 items", inst_o);
        end else if (inst_o !== (32'h0A00_0000 + 32'(rcv)) ||
                     inst_addr_o !== (32'h0000_0200 + 32'(4 * rcv))) begin
          n_bad++;
          $display("FAIL stream_item%0d: got inst=%h addr=%h, want inst=%h addr=%h",
                   rcv, inst_o, inst_addr_o, 32'h0A00_0000 + 32'(rcv),
                   32'h0000_0200 + 32'(4 * rcv));
        end
        rcv++;
      end
      cyc++;
    end
    hold_flag_i = 1'b0; inst_valid_i = 1'b0;
    n_cmp++;
    if (rcv !== 20 || sent !== 20) begin
      n_bad++;
      $display("FAIL stream_count: got sent=%0d rcv=%0d, want 20 20", sent, rcv);
    end
    step();
    chk_out("stream_tail", NOP, 32'h0000_0200 + 32'(4 * 19), 1'b0);
  endtask

  task automatic test_perf_cnt();
    // Fill the FIFO, then reset mid-stream: buffered entries must vanish.
    hold_flag_i = 1'b1; inst_valid_i = 1'b1;
    inst_i = 32'h3000_0000; inst_addr_i = 32'h0000_0400;
    step();
    step();
    rst = 1'b0; hold_flag_i = 1'b0; inst_valid_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk_out("midreset_empty", NOP, 32'h0, 1'b0);
    hold_flag_i = 1'b1;
    for (int i = 0; i < 7; i++) step();
    hold_flag_i = 1'b0;
    jump_flag_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    jump_flag_i = 1'b0;
    step();
    n_cmp++;
`ifdef IF_ID_PERF_CNT_EN
    if (stall_cnt_o !== 32'd7 || flush_cnt_o !== 32'd3) begin
      n_bad++;
      $display("FAIL perf_cnt: got stall=%0d flush=%0d, want 7 3", stall_cnt_o, flush_cnt_o);
    end
`else
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_cnt: got stall=%0d flush=%0d, want 0 0", stall_cnt_o, flush_cnt_o);
    end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; inst_i = 32'h0; inst_addr_i = 32'h0; inst_valid_i = 1'b0;
    hold_flag_i = 1'b0; jump_flag_i = 1'b0;
    #1;
    test_reset();
    test_bypass();
    test_hold_fill();
    test_flush();
    test_stream();
    test_perf_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
